// File: rtl/constraint_sampler_pkg.sv
// Shared types and constants for the constraint sampler.
// Contents: FSM state enum, Galois LFSR tap mask, default seed,
// try-counter width and a one-step LFSR helper used by the LFSR block.
package constraint_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GEN   = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;
  localparam int          TRIES_W      = 16;

  // Bit 31 of the tap mask is set, so a nonzero state never maps to zero.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/constraint_sampler_if.sv
// Handshake/candidate bundle between the sampler and its environment.
// master : solver controller + external checker (drives requests, seed,
//          verdict and response-ready)
// slave  : constraint_sampler (drives candidates and response)
interface constraint_sampler_if
  import constraint_sampler_pkg::*;
#(
  parameter int W_A = 5,
  parameter int W_B = 15
);
  logic               req_valid;
  logic               req_ready;
  logic               seed_load;
  logic [31:0]        seed_in;
  logic [W_A-1:0]     cand_a;
  logic [W_B-1:0]     cand_b;
  logic               chk_x;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W_A-1:0]     rsp_a;
  logic [W_B-1:0]     rsp_b;
  logic               rsp_sat;
  logic [TRIES_W-1:0] rsp_tries;

  modport master (
    output req_valid, seed_load, seed_in, chk_x, rsp_ready,
    input  req_ready, cand_a, cand_b, rsp_valid, rsp_a, rsp_b, rsp_sat, rsp_tries
  );

  modport slave (
    input  req_valid, seed_load, seed_in, chk_x, rsp_ready,
    output req_ready, cand_a, cand_b, rsp_valid, rsp_a, rsp_b, rsp_sat, rsp_tries
  );
endinterface

// File: rtl/cs_lfsr32.sv
// 32-bit right-shifting Galois LFSR with seed load.
// Ports:
//   clk, rst_n  - clock, async active-low reset (state <= SEED)
//   load        - load load_val (a zero load_val is replaced by SEED)
//   load_val    - seed to load
//   adv         - advance one step (load has priority)
//   value       - current LFSR state
module cs_lfsr32
  import constraint_sampler_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        adv,
  output logic [31:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else if (load) begin
      // zero would lock the LFSR, so fall back to the build-time seed
      value <= (load_val == 32'h0) ? SEED : load_val;
    end else if (adv) begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/constraint_sampler.sv
// Constraint sampler: draws pseudo-random (A,B) candidates from an LFSR,
// presents them to an external combinational checker and retries until
// the checker accepts or the try budget runs out, then returns the
// final candidate over a valid/ready response channel.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   bus         - constraint_sampler_if.slave (request, seed, candidates,
//                 checker verdict, response)
//   stat_req, stat_fail, stat_checks - saturating statistics counters,
//                 present only when CONSTRAINT_SAMPLER_STATS_EN is defined
// Optional build macro: CONSTRAINT_SAMPLER_STATS_EN
module constraint_sampler
  import constraint_sampler_pkg::*;
#(
  parameter int          W_A       = 5,
  parameter int          W_B       = 15,
  parameter int          MAX_TRIES = 64,
  parameter logic [31:0] SEED      = DEFAULT_SEED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  constraint_sampler_if.slave   bus
`ifdef CONSTRAINT_SAMPLER_STATS_EN
  ,
  output logic [31:0]           stat_req,
  output logic [31:0]           stat_fail,
  output logic [31:0]           stat_checks
`endif
);

  if (W_A + W_B > 32) begin : g_bad_width
    $error("constraint_sampler: W_A + W_B must not exceed 32");
  end
  if (MAX_TRIES < 1 || MAX_TRIES > 65535) begin : g_bad_tries
    $error("constraint_sampler: MAX_TRIES must be in 1..65535");
  end
  if (SEED == 32'h0) begin : g_bad_seed
    $error("constraint_sampler: SEED must be nonzero");
  end

  localparam logic [TRIES_W-1:0] MAX_T = TRIES_W'(MAX_TRIES);

  state_t             state;
  logic [TRIES_W-1:0] tries;
  logic [W_A-1:0]     cand_a_q;
  logic [W_B-1:0]     cand_b_q;
  logic [W_A-1:0]     rsp_a_q;
  logic [W_B-1:0]     rsp_b_q;
  logic               rsp_sat_q;
  logic [TRIES_W-1:0] rsp_tries_q;
  logic               rsp_valid_q;
  logic [31:0]        lfsr_val;

  logic accept;
  logic last_try;
  logic retry;
  logic finish;
  logic seed_take;
  logic unused_lfsr_bits;

  // seed_load wins over a simultaneous request
  assign seed_take = (state == IDLE) && bus.seed_load;
  assign accept    = (state == IDLE) && !bus.seed_load && bus.req_valid;
  assign last_try  = (tries == MAX_T);
  assign retry     = (state == CHECK) && !bus.chk_x && !last_try;
  assign finish    = (state == CHECK) && (bus.chk_x || last_try);

  // LFSR steps on every entry to GEN, so GEN sees the fresh value
  cs_lfsr32 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (seed_take),
    .load_val (bus.seed_in),
    .adv      (accept || retry),
    .value    (lfsr_val)
  );

  // upper LFSR bits beyond W_A+W_B only feed the sequence, not the candidates
  assign unused_lfsr_bits = ^lfsr_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tries       <= '0;
      cand_a_q    <= '0;
      cand_b_q    <= '0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_sat_q   <= 1'b0;
      rsp_tries_q <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tries <= '0;
            state <= GEN;
          end
        end
        GEN: begin
          cand_a_q <= lfsr_val[W_A-1:0];
          cand_b_q <= lfsr_val[W_A+W_B-1:W_A];
          tries    <= tries + 1'b1;
          state    <= CHECK;
        end
        CHECK: begin
          if (finish) begin
            rsp_a_q     <= cand_a_q;
            rsp_b_q     <= cand_b_q;
            rsp_sat_q   <= bus.chk_x;
            rsp_tries_q <= tries;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            state <= GEN;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) && !bus.seed_load;
  assign bus.cand_a    = cand_a_q;
  assign bus.cand_b    = cand_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_a     = rsp_a_q;
  assign bus.rsp_b     = rsp_b_q;
  assign bus.rsp_sat   = rsp_sat_q;
  assign bus.rsp_tries = rsp_tries_q;

`ifdef CONSTRAINT_SAMPLER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req    <= '0;
      stat_fail   <= '0;
      stat_checks <= '0;
    end else begin
      if (accept && (stat_req != '1)) begin
        stat_req <= stat_req + 32'd1;
      end
      if (finish && !bus.chk_x && (stat_fail != '1)) begin
        stat_fail <= stat_fail + 32'd1;
      end
      if ((state == CHECK) && (stat_checks != '1)) begin
        stat_checks <= stat_checks + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_constraint_sampler.sv
// Directed self-checking bench for constraint_sampler.
// Two instances: u64 (MAX_TRIES=64) and u4 (MAX_TRIES=4), each with its
// own checker driven from a shared mode selector:
//   mode 0: a!=0 && b!=0, mode 1: always 0, mode 2: a==0.
module tb_constraint_sampler;

  localparam logic [31:0] RST_SEED = 32'hACE1_0001;
  localparam logic [31:0] TAPS     = 32'h8020_0003;

  logic clk;
  logic rst_n;
  int   mode;
  int   n_pass;
  int   n_total;

  logic [31:0] m [2];

  logic        req_v  [2];
  logic        seed_ld[2];
  logic [31:0] seed_v [2];
  logic        rsp_r  [2];

  logic        rr  [2];
  logic        rv  [2];
  logic        rsat[2];
  logic [4:0]  ca  [2];
  logic [14:0] cb  [2];
  logic [4:0]  ra  [2];
  logic [14:0] rb  [2];
  logic [15:0] rt  [2];

  constraint_sampler_if #(.W_A(5), .W_B(15)) if64 ();
  constraint_sampler_if #(.W_A(5), .W_B(15)) if4 ();

`ifdef CONSTRAINT_SAMPLER_STATS_EN
  logic [31:0] s64_req, s64_fail, s64_chk;
  logic [31:0] s4_req, s4_fail, s4_chk;
`endif

  constraint_sampler #(.W_A(5), .W_B(15), .MAX_TRIES(64), .SEED(RST_SEED)) u64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if64.slave)
`ifdef CONSTRAINT_SAMPLER_STATS_EN
    ,
    .stat_req    (s64_req),
    .stat_fail   (s64_fail),
    .stat_checks (s64_chk)
`endif
  );

  constraint_sampler #(.W_A(5), .W_B(15), .MAX_TRIES(4), .SEED(RST_SEED)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
`ifdef CONSTRAINT_SAMPLER_STATS_EN
    ,
    .stat_req    (s4_req),
    .stat_fail   (s4_fail),
    .stat_checks (s4_chk)
`endif
  );

  function automatic logic chk_fn(input logic [4:0] a, input logic [14:0] b, input int md);
    case (md)
      0:       return (a != 5'd0) && (b != 15'd0);
      2:       return (a == 5'd0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
  endfunction

  assign if64.req_valid = req_v[0];
  assign if64.seed_load = seed_ld[0];
  assign if64.seed_in   = seed_v[0];
  assign if64.rsp_ready = rsp_r[0];
  assign if64.chk_x     = chk_fn(if64.cand_a, if64.cand_b, mode);
  assign if4.req_valid  = req_v[1];
  assign if4.seed_load  = seed_ld[1];
  assign if4.seed_in    = seed_v[1];
  assign if4.rsp_ready  = rsp_r[1];
  assign if4.chk_x      = chk_fn(if4.cand_a, if4.cand_b, mode);

  assign rr[0] = if64.req_ready;  assign rr[1] = if4.req_ready;
  assign rv[0] = if64.rsp_valid;  assign rv[1] = if4.rsp_valid;
  assign rsat[0] = if64.rsp_sat;  assign rsat[1] = if4.rsp_sat;
  assign ca[0] = if64.cand_a;     assign ca[1] = if4.cand_a;
  assign cb[0] = if64.cand_b;     assign cb[1] = if4.cand_b;
  assign ra[0] = if64.rsp_a;      assign ra[1] = if4.rsp_a;
  assign rb[0] = if64.rsp_b;      assign rb[1] = if4.rsp_b;
  assign rt[0] = if64.rsp_tries;  assign rt[1] = if4.rsp_tries;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference walk: advance the model per try until the checker would accept.
  task automatic model_req(input int d, input int maxt, output logic esat,
                           output logic [15:0] etries, output logic [4:0] ea,
                           output logic [14:0] eb);
    esat = 1'b0; etries = '0; ea = '0; eb = '0;
    for (int k = 1; k <= maxt; k++) begin
      m[d]   = step(m[d]);
      ea     = m[d][4:0];
      eb     = m[d][19:5];
      etries = 16'(k);
      if (chk_fn(ea, eb, mode)) begin
        esat = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_req(input int d, input int hold, output logic sat,
                         output logic [15:0] tries, output logic [4:0] a,
                         output logic [14:0] b, output int lat,
                         output int unstable, output logic post_rr,
                         output logic post_rv);
    @(negedge clk);
    req_v[d] = 1'b1;
    @(negedge clk);
    req_v[d] = 1'b0;
    lat = 1;
    while (!rv[d] && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (!rv[d]) begin
      $display("FAIL rsp_timeout dut=%0d: no rsp_valid after %0d cycles, required within 300", d, lat);
      n_total++;
    end
    sat = rsat[d]; tries = rt[d]; a = ra[d]; b = rb[d];
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rv[d] || rr[d] || rsat[d] !== sat || rt[d] !== tries || ra[d] !== a || rb[d] !== b)
        unstable++;
    end
    rsp_r[d] = 1'b1;
    @(negedge clk);
    rsp_r[d] = 1'b0;
    post_rr = rr[d];
    post_rv = rv[d];
  endtask

  task automatic test_reset();
    logic [58:0] got;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      got = {rr[d], rv[d], ca[d], cb[d], ra[d], rb[d], rsat[d], rt[d]};
      n_total++;
      if (got !== {1'b1, 58'd0})
        $display("FAIL reset_outputs dut=%0d got=%h required=%h", d, got, {1'b1, 58'd0});
      else n_pass++;
    end
    rst_n = 1'b1;
    m[0] = RST_SEED;
    m[1] = RST_SEED;
    @(negedge clk);
  endtask

  task automatic test_first_try();
    logic sat, esat, prr, prv;
    logic [15:0] tr, etr;
    logic [4:0] a, ea;
    logic [14:0] b, eb;
    int lat, uns;
    mode = 0;
    model_req(0, 64, esat, etr, ea, eb);
    run_req(0, 0, sat, tr, a, b, lat, uns, prr, prv);
    // first step from ACE10001 is D6508003: a=3, b=0x400
    n_total++; if (sat !== 1'b1) $display("FAIL first_sat got=%0b required=1", sat); else n_pass++;
    n_total++; if (tr !== 16'd1) $display("FAIL first_tries got=%0d required=1", tr); else n_pass++;
    n_total++; if (a !== 5'd3) $display("FAIL first_a got=%0d required=3", a); else n_pass++;
    n_total++; if (b !== 15'd1024) $display("FAIL first_b got=%0d required=1024", b); else n_pass++;
    n_total++; if (lat != 3) $display("FAIL first_latency got=%0d required=3", lat); else n_pass++;
  endtask

  task automatic test_budget();
    logic sat, esat, prr, prv;
    logic [15:0] tr, etr;
    logic [4:0] a, ea;
    logic [14:0] b, eb;
    int lat, uns;
    mode = 1;
    model_req(1, 4, esat, etr, ea, eb);
    run_req(1, 0, sat, tr, a, b, lat, uns, prr, prv);
    n_total++; if (sat !== 1'b0) $display("FAIL budget_sat got=%0b required=0", sat); else n_pass++;
    n_total++; if (tr !== 16'd4) $display("FAIL budget_tries got=%0d required=4", tr); else n_pass++;
    n_total++; if (lat != 9) $display("FAIL budget_latency got=%0d required=9", lat); else n_pass++;
    n_total++; if ({a, b} !== {ea, eb}) $display("FAIL budget_cand got=%0d/%0d required=%0d/%0d", a, b, ea, eb); else n_pass++;
  endtask

  task automatic test_seeded_search();
    logic sat, esat, prr, prv;
    logic [15:0] tr, etr;
    logic [4:0] a, ea;
    logic [14:0] b, eb;
    int lat, uns;
    @(negedge clk);
    seed_ld[0] = 1'b1; seed_v[0] = 32'h1;
    @(negedge clk);
    seed_ld[0] = 1'b0;
    m[0] = 32'h1;
    mode = 2;
    model_req(0, 64, esat, etr, ea, eb);
    run_req(0, 0, sat, tr, a, b, lat, uns, prr, prv);
    n_total++; if (sat !== esat) $display("FAIL seeded_sat got=%0b required=%0b", sat, esat); else n_pass++;
    n_total++; if (tr !== etr) $display("FAIL seeded_tries got=%0d required=%0d", tr, etr); else n_pass++;
    n_total++; if ({a, b} !== {ea, eb}) $display("FAIL seeded_cand got=%0d/%0d required=%0d/%0d", a, b, ea, eb); else n_pass++;
    n_total++; if (lat != 2 * int'(etr) + 1) $display("FAIL seeded_latency got=%0d required=%0d", lat, 2 * int'(etr) + 1); else n_pass++;
  endtask

  task automatic test_seed_zero_with_req();
    logic sat, esat, prr, prv;
    logic [15:0] tr, etr;
    logic [4:0] a, ea;
    logic [14:0] b, eb;
    int lat, uns;
    @(negedge clk);
    seed_ld[0] = 1'b1; seed_v[0] = 32'h0; req_v[0] = 1'b1;
    #1;
    n_total++; if (rr[0] !== 1'b0) $display("FAIL seedload_req_ready got=%0b required=0", rr[0]); else n_pass++;
    @(negedge clk);
    seed_ld[0] = 1'b0; req_v[0] = 1'b0;
    #1;
    n_total++; if (rr[0] !== 1'b1) $display("FAIL seedload_req_ignored got=%0b required=1", rr[0]); else n_pass++;
    m[0] = RST_SEED;
    mode = 0;
    model_req(0, 64, esat, etr, ea, eb);
    run_req(0, 0, sat, tr, a, b, lat, uns, prr, prv);
    n_total++;
    if ({sat, tr, a, b} !== {1'b1, 16'd1, 5'd3, 15'd1024})
      $display("FAIL seedload_replay got=%0b/%0d/%0d/%0d required=1/1/3/1024", sat, tr, a, b);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic sat, esat, prr, prv;
    logic [15:0] tr, etr;
    logic [4:0] a, ea;
    logic [14:0] b, eb;
    int lat, uns;
    mode = 0;
    model_req(1, 4, esat, etr, ea, eb);
    run_req(1, 10, sat, tr, a, b, lat, uns, prr, prv);
    n_total++; if ({sat, tr, a, b} !== {esat, etr, ea, eb})
      $display("FAIL bp_result got=%0b/%0d/%0d/%0d required=%0b/%0d/%0d/%0d", sat, tr, a, b, esat, etr, ea, eb);
    else n_pass++;
    n_total++; if (uns != 0) $display("FAIL bp_stable unstable_cycles=%0d required=0", uns); else n_pass++;
    n_total++; if ({prr, prv} !== 2'b10) $display("FAIL bp_after_handshake ready/valid got=%b required=10", {prr, prv}); else n_pass++;
  endtask

  task automatic test_reset_mid_check();
    logic [58:0] got;
    int pulses;
    mode = 1;
    @(negedge clk);
    req_v[0] = 1'b1;
    @(negedge clk);
    req_v[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = {rr[0], rv[0], ca[0], cb[0], ra[0], rb[0], rsat[0], rt[0]};
    n_total++;
    if (got !== {1'b1, 58'd0}) $display("FAIL midreset_outputs got=%h required=%h", got, {1'b1, 58'd0});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    m[0] = RST_SEED;
    m[1] = RST_SEED;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rv[0]) pulses++;
    end
    n_total++; if (pulses != 0) $display("FAIL midreset_no_rsp rsp_valid_cycles=%0d required=0", pulses); else n_pass++;
  endtask

`ifdef CONSTRAINT_SAMPLER_STATS_EN
  task automatic test_stats();
    logic sat, esat, prr, prv;
    logic [15:0] tr, etr;
    logic [4:0] a, ea;
    logic [14:0] b, eb;
    int lat, uns, sum;
    sum = 0;
    for (int r = 0; r < 3; r++) begin
      mode = (r == 1) ? 1 : 0;
      model_req(1, 4, esat, etr, ea, eb);
      sum += int'(etr);
      run_req(1, 0, sat, tr, a, b, lat, uns, prr, prv);
    end
    n_total++; if (s4_req !== 32'd3) $display("FAIL stat_req got=%0d required=3", s4_req); else n_pass++;
    n_total++; if (s4_fail !== 32'd1) $display("FAIL stat_fail got=%0d required=1", s4_fail); else n_pass++;
    n_total++; if (s4_chk !== 32'(sum)) $display("FAIL stat_checks got=%0d required=%0d", s4_chk, sum); else n_pass++;
  endtask
`endif

  initial begin
    n_pass = 0; n_total = 0; mode = 0;
    for (int d = 0; d < 2; d++) begin
      req_v[d] = 1'b0; seed_ld[d] = 1'b0; seed_v[d] = 32'h0; rsp_r[d] = 1'b0;
    end
    test_reset();
    test_first_try();
    test_budget();
    test_seeded_search();
    test_seed_zero_with_req();
    test_backpressure();
    test_reset_mid_check();
`ifdef CONSTRAINT_SAMPLER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/constraint_sampler.md
Name: constraint_sampler

Overview:
- Stimulus-side counterpart to the generated constraint checkers: produces candidate assignments for two solver variables, drives them into an external combinational checker, and reads back its 1-bit verdict.
- Retries with fresh pseudo-random candidates until the checker returns 1 or a try budget runs out.
- Returns the satisfying (or last) assignment over a valid/ready response channel.
- Sits between the solver testbench/controller and any split_N checker instance.

Parameters:
- W_A, 5, width of candidate A (maps to a narrow variable, e.g. 5-bit).
- W_B, 15, width of candidate B; elaboration error if W_A+W_B > 32.
- MAX_TRIES, 64, try budget per request, range 1..65535.
- SEED, 32'hACE1_0001, LFSR reset value; must be nonzero.

Ports:
- clk, input, 1, single clock.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, start-sampling request.
- req_ready, output, 1, high only in IDLE.
- seed_load, input, 1, load seed_in into LFSR; honoured only in IDLE.
- seed_in, input, 32, new seed; value 0 is replaced by SEED.
- cand_a, output, W_A, candidate A to checker (registered).
- cand_b, output, W_B, candidate B to checker (registered).
- chk_x, input, 1, checker verdict for current cand_a/cand_b.
- rsp_valid, output, 1, response available.
- rsp_ready, input, 1, response accepted.
- rsp_a, output, W_A, result A.
- rsp_b, output, W_B, result B.
- rsp_sat, output, 1, 1 = checker satisfied, 0 = budget exhausted.
- rsp_tries, output, 16, number of candidates checked (1..MAX_TRIES).

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State IDLE; LFSR = SEED; try counter = 0.
  - cand_a/cand_b = 0; all rsp_* = 0; rsp_valid = 0; req_ready = 1.
- LFSR: 32-bit Galois, taps mask 32'h8020_0003 (x^32+x^22+x^2+x+1), shifts right by one per advance. Advances only on entry to GEN. Never reaches 0.
- Candidate slicing: cand_a = lfsr[W_A-1:0]; cand_b = lfsr[W_A+W_B-1:W_A], taken from the post-advance value.
- FSM:
  - IDLE:
    - seed_load has priority: LFSR = (seed_in==0 ? SEED : seed_in), stay IDLE, and any req_valid that cycle is ignored (req_ready is forced low that cycle).
    - Else req_valid&&req_ready: tries = 0 -> GEN.
  - GEN (1 cycle): advance LFSR, register cand_a/cand_b, tries += 1 -> CHECK.
  - CHECK (1 cycle): sample chk_x against the registered candidates.
    - chk_x=1: latch rsp_a/rsp_b = cand, rsp_sat = 1, rsp_tries = tries -> RESP.
    - chk_x=0 and tries == MAX_TRIES: same latch, rsp_sat = 0 -> RESP.
    - Otherwise -> GEN.
  - RESP: rsp_valid = 1; rsp_* held stable until rsp_valid&&rsp_ready, then -> IDLE and rsp_valid = 0 next cycle.
- Latency: 2 cycles per try. The cycle of req acceptance to rsp_valid is 2*k+1 cycles for a success on try k.
- Boundaries:
  - MAX_TRIES=1 gives exactly one check.
  - tries never exceeds MAX_TRIES.
  - cand_* hold their last value outside GEN.
  - chk_x is ignored outside CHECK.
  - Reset mid-operation aborts immediately with no response.
  - New requests cannot be accepted while rsp_valid is high.

Optional Feature:
- Macro: CONSTRAINT_SAMPLER_STATS_EN.
- Enabled: adds outputs stat_req (32), stat_fail (32) and stat_checks (32). These are saturating counters of accepted requests, unsatisfied responses and total CHECK cycles. All are cleared by reset.
- Disabled: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package constraint_sampler_pkg: state enum (IDLE, GEN, CHECK, RESP), LFSR_TAPS constant, DEFAULT_SEED constant, TRIES_W = 16.
- One sub-module: cs_lfsr32 (clk, rst_n, load, load_val, adv, value), holding the Galois LFSR and zero-seed substitution.

Test Plan:
- Checker = |(a && b) (both nonzero), SEED default, MAX_TRIES=64, req pulse -> rsp_sat=1, rsp_tries=1, rsp_a≠0, rsp_b≠0, rsp_valid 3 cycles after acceptance.
- Checker tied 0, MAX_TRIES=4 -> rsp_sat=0, rsp_tries=4, rsp_valid at cycle 9; rsp_a/rsp_b equal the 4th candidate from the reference LFSR model.
- Checker = (a==5'd0), MAX_TRIES=64, seed 32'h1 -> result matches the software LFSR model try-for-try (sat at the first model index with a==0, or fail at 64).
- seed_load with seed_in=0 together with req_valid -> request ignored, LFSR = 32'hACE1_0001; next request reproduces the reset-seed sequence.
- rsp_ready held low 10 cycles -> rsp_* stable and req_ready=0 throughout; after handshake, req_ready=1 next cycle.
- rst_n asserted during CHECK -> all outputs 0 immediately and rsp_valid never pulses. With STATS_EN, stat_req=3 and stat_fail=1 after a scripted sequence of 3 requests, one of which fails.
